// File: rtl/imem_boot_ctrl.sv
// Boot controller for a byte-addressed instruction memory: clears it, loads an
// image from the host byte stream, then releases the core and checks its fetches.
module imem_boot_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  input  logic          byte_last_i,
  output logic          byte_ready_o,
  input  logic [63:0]   pc_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_wadr_o,
  output logic [7:0]    mem_wdata_o,
  output logic [63:0]   mem_radr_o,
  output logic          cpu_run_o,
  output logic          fetch_fault_o,
  output logic          load_done_o,
  output logic          load_err_o,
  output logic [AW:0]   byte_count_o
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_ptr_q;
  logic          pend_q;
  logic          load_done_q;
  logic          load_err_q;
  logic [AW:0]   byte_count_q;

  logic accept;
  logic clr_end;
  logic cnt_end;

  assign accept  = (state_q == S_LOAD) && byte_valid_i;
  assign clr_end = (clr_ptr_q == AW'(DEPTH - 1));
  assign cnt_end = (byte_count_q[AW-1:0] == AW'(DEPTH - 1));

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      pend_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + AW'(1);
          // A request arriving on the final clear cycle still counts as pending.
          if (clr_end) begin
            state_q <= (pend_q || load_start_i) ? S_LOAD : S_IDLE;
            pend_q  <= 1'b0;
          end else if (load_start_i) begin
            pend_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (load_start_i) begin
            state_q      <= S_LOAD;
            byte_count_q <= '0;
            load_err_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            byte_count_q <= byte_count_q + (AW+1)'(1);
            if (byte_last_i) begin
              state_q     <= S_RUN;
              load_done_q <= 1'b1;
            end else if (cnt_end) begin
              state_q     <= S_IDLE;
              load_err_q  <= 1'b1;
              load_done_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (load_start_i) begin
            state_q      <= S_CLEAR;
            pend_q       <= 1'b1;
            clr_ptr_q    <= '0;
            load_done_q  <= 1'b0;
            byte_count_q <= '0;
            load_err_q   <= 1'b0;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    byte_ready_o  = (state_q == S_LOAD);
    mem_we_o      = 1'b0;
    mem_wadr_o    = '0;
    mem_wdata_o   = '0;
    cpu_run_o     = (state_q == S_RUN);
    mem_radr_o    = '0;
    fetch_fault_o = 1'b0;
    if (state_q == S_CLEAR) begin
      mem_we_o   = 1'b1;
      mem_wadr_o = clr_ptr_q;
    end else if (accept) begin
      mem_we_o    = 1'b1;
      mem_wadr_o  = byte_count_q[AW-1:0];
      mem_wdata_o = byte_data_i;
    end
    if (state_q == S_RUN) begin
      mem_radr_o    = pc_i;
      fetch_fault_o = (pc_i[1:0] != 2'b00) || (pc_i > 64'(DEPTH - 4));
    end
  end

  assign load_done_o  = load_done_q;
  assign load_err_o   = load_err_q;
  assign byte_count_o = byte_count_q;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and access controller for the 64-byte, byte-addressed instruction memory. After reset it clears the memory, then accepts a byte stream from the host loader over a valid/ready handshake and writes it from address 0 upward. Once the image is complete it releases the core (`cpu_run`) and routes the core's fetch address to the memory read port, flagging misaligned or out-of-range fetches. It sits between the host/loader interface, the instruction memory write and read ports, and the core's PC.

## Interface
- `DEPTH`, 64: memory size in bytes; power of two, ≥ 8.
- `AW`, 6: write-address width, equal to log2(`DEPTH`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `load_start`  in  1  one-cycle request to (re)load an image.
- `byte_valid`  in  1  loader byte present.
- `byte_data`  in  8  loader byte.
- `byte_last`  in  1  qualifies the final byte of the image; sampled with `byte_valid`.
- `byte_ready`  out  1  controller accepts a byte this cycle.
- `pc`  in  64  core fetch address (byte address).
- `mem_we`  out  1  memory byte write enable.
- `mem_wadr`  out  AW  memory byte write address.
- `mem_wdata`  out  8  memory byte write data.
- `mem_radr`  out  64  memory read address (word = bytes radr..radr+3, little-endian).
- `cpu_run`  out  1  core released from hold.
- `fetch_fault`  out  1  current `pc` is illegal (only asserted while running).
- `load_done`  out  1  sticky: a valid image has been loaded.
- `load_err`  out  1  sticky: the last load overflowed.
- `byte_count`  out  AW+1  number of bytes accepted in the current or last load.

## Operation
- FSM states: CLEAR, IDLE, LOAD, RUN. An asynchronous `rst` forces CLEAR with the clear pointer at 0 and clears `load_done`, `load_err`, `byte_count` and the `pend` flag.
- **CLEAR**
  - `mem_we`=1, `mem_wdata`=0x00, `mem_wadr`=clear pointer; the pointer increments every cycle.
  - After writing address `DEPTH`-1: go to LOAD if `pend`=1 (clearing `pend`), otherwise go to IDLE.
  - `byte_ready`=0.
- **IDLE**
  - `load_start`=1 → LOAD; `byte_count`←0, `load_err`←0.
- **LOAD**
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid`=1 and `byte_ready`=1. On acceptance: `mem_we`=1, `mem_wadr`=`byte_count`[AW-1:0], `mem_wdata`=`byte_data`, and `byte_count` increments.
  - Accepted byte with `byte_last`=1 → RUN, `load_done`←1.
  - Accepted byte at address `DEPTH`-1 with `byte_last`=0 → IDLE, `load_err`←1, `load_done`←0.
  - `load_start` is ignored while in LOAD.
- **RUN**
  - `cpu_run`=1 and `mem_radr`=`pc`.
  - `fetch_fault`=1 when `pc`[1:0]≠0 or `pc` > `DEPTH`-4, evaluated as a 64-bit unsigned compare.
  - `load_start`=1 → CLEAR with `pend`←1, clear pointer←0, `load_done`←0, `byte_count`←0, `load_err`←0.
- **Outputs outside their active state**
  - `mem_radr`=0, `cpu_run`=0, `fetch_fault`=0 outside RUN.
  - `mem_we`=0, `mem_wadr`=0, `mem_wdata`=0 outside CLEAR and accepted-LOAD cycles.
- `load_start` arriving during CLEAR sets `pend`, so the controller enters LOAD directly after the clear completes.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=1 (CLEAR, address 0, data 0x00), `mem_radr`=0, `cpu_run`=0, `fetch_fault`=0, `load_done`=0, `load_err`=0, `byte_count`=0.
- CLEAR lasts exactly `DEPTH` cycles.
- `byte_ready`, `mem_we`, `mem_wadr` and `mem_wdata` are combinational from state and inputs; the memory captures the write on the same rising edge that accepts the byte.
- Throughput in LOAD: one byte per cycle.
- After the edge that accepts the last byte, `cpu_run`=1 in the next cycle.
- `fetch_fault` and `mem_radr` are combinational from `pc` with zero latency.
- `load_start`=1 in RUN: `cpu_run` deasserts in the next cycle, followed by `DEPTH` clear cycles and then LOAD.
- A single byte with `byte_last`=1 is a valid 1-byte image.
- Reset asserted mid-LOAD or mid-RUN aborts the operation; partially written bytes are zeroed by the following CLEAR.

## Test plan
- Reset, then hold 64 cycles → `mem_we`=1 with addresses 0..63 and data 0x00, state IDLE afterwards, `byte_ready`=0, `cpu_run`=0.
- Pulse `load_start`, stream 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with `byte_last` on the 8th byte (`byte_valid` dropped for 2 cycles mid-stream) → writes to addresses 0..7, `byte_count`=8, `load_done`=1, `cpu_run`=1 next cycle; `pc`=4 → `mem_radr`=4, word reads 0x00100093.
- In RUN: `pc`=2 → `fetch_fault`=1; `pc`=60 → 0; `pc`=61 → 1; `pc`=64 → 1; `pc`=0xFFFF_FFFF_FFFF_FFFC → 1.
- Stream 64 bytes with no `byte_last` → 64th byte accepted, state IDLE, `load_err`=1, `load_done`=0, `cpu_run`=0; a 65th `byte_valid` sees `byte_ready`=0.
- In RUN pulse `load_start` → `cpu_run`=0 next cycle, 64 clear writes, then `byte_ready`=1 without a further `load_start`; `load_start` pulsed during CLEAR gives the same result.
- Assert `rst` asynchronously mid-LOAD at `byte_count`=5 → outputs take reset values immediately, without waiting for a clock edge; the next 64 cycles zero addresses 0..63.
